// File: rtl/bus_arbiter_2_1_if.sv
// Request/grant and shared-channel signals between two bus masters and the 2:1 arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_2_1_if #(
    parameter int DATA_W = 8
);
    logic              Req0;
    logic              Req1;
    logic [DATA_W-1:0] CH0;
    logic [DATA_W-1:0] CH1;
    logic              Gnt0;
    logic              Gnt1;
    logic              Sel;
    logic              Busy;
    logic [DATA_W-1:0] Out;

    modport master (
        output Req0, Req1, CH0, CH1,
        input  Gnt0, Gnt1, Sel, Busy, Out
    );

    modport slave (
        input  Req0, Req1, CH0, CH1,
        output Gnt0, Gnt1, Sel, Busy, Out
    );
endinterface

// File: rtl/bus_arbiter_2_1.sv
// Round-robin 2:1 arbiter with built-in channel mux; ARB_TIMEOUT_EN adds forced handover after HOLD_MAX cycles.
// Latency: request to grant 1 cycle, release to handover 1 cycle; Out is combinational from registered select.
// Backpressure: a requester holds its request until granted; no queuing, a dropped request is simply not served.
module bus_arbiter_2_1 #(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    bus_arbiter_2_1_if.slave      bus
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("bus_arbiter_2_1: HOLD_MAX must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t nxt;
    logic   gnt0;
    logic   gnt1;
    logic   sel;
    logic   busy;
    logic   last_gnt;
    logic   hold_expired;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt;
    assign hold_expired = (hold_cnt >= HOLD_LAST);
`else
    assign hold_expired = 1'b0;
`endif

    // An owner keeps the path until it releases, or (timeout build) until it
    // has held long enough and the other side is waiting.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (bus.Req0 && (!bus.Req1 || last_gnt))
                    nxt = GRANT0;
                else if (bus.Req1)
                    nxt = GRANT1;
            end
            GRANT0: begin
                if (!bus.Req0 || (hold_expired && bus.Req1))
                    nxt = bus.Req1 ? GRANT1 : IDLE;
            end
            GRANT1: begin
                if (!bus.Req1 || (hold_expired && bus.Req0))
                    nxt = bus.Req0 ? GRANT0 : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= 1'b0;
            busy     <= 1'b0;
            last_gnt <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            state <= nxt;
            gnt0  <= (nxt == GRANT0);
            gnt1  <= (nxt == GRANT1);
            sel   <= (nxt == GRANT1);
            busy  <= (nxt != IDLE);
            if (nxt != state && nxt != IDLE)
                last_gnt <= (nxt == GRANT1);
`ifdef ARB_TIMEOUT_EN
            // Saturates at HOLD_LAST so a lone owner can hold indefinitely.
            if (nxt != state)
                hold_cnt <= 8'd0;
            else if (state != IDLE && !hold_expired)
                hold_cnt <= hold_cnt + 8'd1;
`endif
        end
    end

    assign bus.Gnt0 = gnt0;
    assign bus.Gnt1 = gnt1;
    assign bus.Sel  = sel;
    assign bus.Busy = busy;
    assign bus.Out  = sel ? bus.CH1 : (gnt0 ? bus.CH0 : {DATA_W{1'b0}});

endmodule

// File: tb/tb_bus_arbiter_2_1.sv
// Randomized and directed bench for bus_arbiter_2_1 against a transaction-level owner model.
// Covers reset, single request, tie, fairness, async reset mid-grant and timeout (ARB_TIMEOUT_EN aware).
module tb_bus_arbiter_2_1;

    localparam int DATA_W   = 8;
    localparam int HOLD_MAX = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    bus_arbiter_2_1_if #(.DATA_W(DATA_W)) bus ();

    bus_arbiter_2_1 #(.DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the path (-1 none), who was served last, cycles held.
    int m_owner = -1;
    int m_last  = 1;
    int m_held  = 0;

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 1;
        m_held  = 0;
    endfunction

    function automatic void model_grant(int who);
        m_owner = who;
        m_last  = who;
        m_held  = 0;
    endfunction

    function automatic void model_edge(bit r0, bit r1);
        bit mine;
        bit other;
        if (m_owner < 0) begin
            if (r0 && r1)  model_grant(1 - m_last);
            else if (r0)   model_grant(0);
            else if (r1)   model_grant(1);
        end else begin
            mine  = (m_owner == 0) ? r0 : r1;
            other = (m_owner == 0) ? r1 : r0;
            if (!mine) begin
                if (other) model_grant(1 - m_owner);
                else       m_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (other && m_held >= HOLD_MAX - 1) begin
                model_grant(1 - m_owner);
            end else if (m_held < HOLD_MAX - 1) begin
                m_held = m_held + 1;
            end
`endif
        end
    endfunction

    function automatic logic [DATA_W-1:0] model_out();
        if (m_owner == 0) return bus.CH0;
        if (m_owner == 1) return bus.CH1;
        return '0;
    endfunction

    task automatic step();
        @(posedge Clk);
        model_edge(bus.Req0, bus.Req1);
        #1;
    endtask

    task automatic test_reset();
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        bus.CH0  = 8'h11;
        bus.CH1  = 8'h22;
        Rst      = 1'b1;
        model_reset();
        #12;
        n_checks++; if (bus.Gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b want 0", bus.Gnt0); end
        n_checks++; if (bus.Gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b want 0", bus.Gnt1); end
        n_checks++; if (bus.Sel  !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", bus.Sel); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        n_checks++; if (bus.Out  !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", bus.Out); end
        Rst = 1'b0;
        step();
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.Busy); end
    endtask

    task automatic test_single();
        bus.Req0 = 1'b1;
        bus.CH0  = 8'hA5;
        step();
        n_checks++; if (bus.Gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0: got %b want 1", bus.Gnt0); end
        n_checks++; if (bus.Out !== 8'hA5) begin n_fail++; $display("FAIL single_out: got %h want a5", bus.Out); end
        n_checks++; if (bus.Sel !== 1'b0 || bus.Busy !== 1'b1) begin n_fail++; $display("FAIL single_sel_busy: got %b%b want 01", bus.Sel, bus.Busy); end
        bus.Req0 = 1'b0;
        step();
        n_checks++; if (bus.Gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b want 0", bus.Gnt0); end
        n_checks++; if (bus.Out !== 8'h00) begin n_fail++; $display("FAIL single_idle_out: got %h want 00", bus.Out); end
    endtask

    task automatic test_tie();
        #2 Rst = 1'b1;
        #2 Rst = 1'b0;
        model_reset();
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b1;
        bus.CH0  = 8'hA5;
        bus.CH1  = 8'h3C;
        step();
        n_checks++; if (bus.Gnt0 !== 1'b1 || bus.Gnt1 !== 1'b0) begin n_fail++; $display("FAIL tie_first: got gnt0=%b gnt1=%b want 1 0", bus.Gnt0, bus.Gnt1); end
        bus.Req0 = 1'b0;
        step();
        n_checks++; if (bus.Gnt1 !== 1'b1 || bus.Gnt0 !== 1'b0) begin n_fail++; $display("FAIL tie_handover: got gnt0=%b gnt1=%b want 0 1", bus.Gnt0, bus.Gnt1); end
        n_checks++; if (bus.Sel !== 1'b1) begin n_fail++; $display("FAIL tie_sel: got %b want 1", bus.Sel); end
        n_checks++; if (bus.Out !== 8'h3C) begin n_fail++; $display("FAIL tie_out: got %h want 3c", bus.Out); end
        bus.Req1 = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        int exp_who;
        int got_who;
        int extra;
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b1;
        exp_who  = 1 - m_last;
        step();
        for (int t = 0; t < 10; t++) begin
            got_who = bus.Gnt1 ? 1 : (bus.Gnt0 ? 0 : -1);
            n_checks++;
            if (got_who !== exp_who) begin
                n_fail++;
                $display("FAIL fair_turn %0d: got %0d want %0d", t, got_who, exp_who);
            end
            extra = $urandom_range(0, 2);
            for (int k = 0; k < extra; k++) step();
            if (exp_who == 0) bus.Req0 = 1'b0; else bus.Req1 = 1'b0;
            step();
            bus.Req0 = 1'b1;
            bus.Req1 = 1'b1;
            exp_who  = 1 - exp_who;
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b1;
        step();
        n_checks++; if (bus.Gnt1 !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got gnt1=%b want 1", bus.Gnt1); end
        #2 Rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (bus.Gnt1 !== 1'b0 || bus.Sel !== 1'b0 || bus.Busy !== 1'b0) begin
            n_fail++; $display("FAIL areset_drop: got gnt1=%b sel=%b busy=%b want 000", bus.Gnt1, bus.Sel, bus.Busy);
        end
        n_checks++; if (bus.Out !== 8'h00) begin n_fail++; $display("FAIL areset_out: got %h want 00", bus.Out); end
        bus.Req0 = 1'b1;
        #2 Rst = 1'b0;
        step();
        n_checks++; if (bus.Gnt0 !== 1'b1 || bus.Gnt1 !== 1'b0) begin n_fail++; $display("FAIL areset_tie: got gnt0=%b gnt1=%b want 1 0", bus.Gnt0, bus.Gnt1); end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int held;
        int exp_held;
        bit exp_g1;
`ifdef ARB_TIMEOUT_EN
        exp_held = HOLD_MAX;
        exp_g1   = 1'b1;
`else
        exp_held = 21;
        exp_g1   = 1'b0;
`endif
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b0;
        step();
        held     = 1;
        bus.Req1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.Gnt0) break;
            held++;
        end
        n_checks++; if (held !== exp_held) begin n_fail++; $display("FAIL timeout_hold: got %0d cycles want %0d", held, exp_held); end
        n_checks++; if (bus.Gnt1 !== exp_g1) begin n_fail++; $display("FAIL timeout_gnt1: got %b want %b", bus.Gnt1, exp_g1); end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        step();
    endtask

    task automatic test_random();
        bit e_g0;
        bit e_g1;
        logic [DATA_W-1:0] e_out;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus.Req0 = ~bus.Req0;
            if ($urandom_range(0, 3) == 0) bus.Req1 = ~bus.Req1;
            bus.CH0 = 8'($urandom);
            bus.CH1 = 8'($urandom);
            step();
            e_g0  = (m_owner == 0);
            e_g1  = (m_owner == 1);
            e_out = model_out();
            n_checks++;
            if (bus.Gnt0 !== e_g0 || bus.Gnt1 !== e_g1 || bus.Sel !== e_g1 || bus.Busy !== (e_g0 | e_g1)) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: got g0=%b g1=%b sel=%b busy=%b want g0=%b g1=%b",
                         c, bus.Gnt0, bus.Gnt1, bus.Sel, bus.Busy, e_g0, e_g1);
            end
            n_checks++;
            if (bus.Out !== e_out) begin
                n_fail++;
                $display("FAIL rand_out cyc %0d: got %h want %h", c, bus.Out, e_out);
            end
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_async_reset();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
